// File: rtl/mmu_data_port.sv
// Memory-side consumer of the MFU request stream: word RAM with byte stores, byte console I/O,
// and load/input results returned on a valid/ready CDB port. One request in flight at a time.
module mmu_data_port #(
    parameter int unsigned RSV_ID_W    = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned INSTR_W     = 6,
    parameter int unsigned CDB_W       = RSV_ID_W + DATA_W,
    parameter int unsigned DRAM_ADDR_W = 10
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [RSV_ID_W-1:0] mmu_rsv_id,
    input  logic                mmu_valid,
    input  logic [DATA_W-1:0]   mmu_data,
    input  logic [DATA_W-1:0]   mmu_addr,
    input  logic [INSTR_W-1:0]  mmu_opcode,
    output logic                mmu_ready,
    output logic [CDB_W-1:0]    mmu_cdb,
    output logic                mmu_cdb_valid,
    input  logic                mmu_cdb_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);

    localparam logic [INSTR_W-1:0] I_LOAD   = INSTR_W'(1);
    localparam logic [INSTR_W-1:0] I_LOADR  = INSTR_W'(2);
    localparam logic [INSTR_W-1:0] I_LOADB  = INSTR_W'(3);
    localparam logic [INSTR_W-1:0] I_STORE  = INSTR_W'(4);
    localparam logic [INSTR_W-1:0] I_STORER = INSTR_W'(5);
    localparam logic [INSTR_W-1:0] I_STOREB = INSTR_W'(6);
    localparam logic [INSTR_W-1:0] I_INPUT  = INSTR_W'(7);
    localparam logic [INSTR_W-1:0] I_OUTPUT = INSTR_W'(8);

    typedef enum logic [2:0] {StIdle, StRead, StResp, StInWait, StOutWait} state_e;

    state_e                 state_q, state_d;
    logic [RSV_ID_W-1:0]    rsv_q, rsv_d;
    logic [DRAM_ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]             lane_q, lane_d;
    logic                   byte_q, byte_d;
    logic [CDB_W-1:0]       cdb_q, cdb_d;
    logic                   cdb_valid_q, cdb_valid_d;
    logic                   ready_q, ready_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;

    logic [DATA_W-1:0]      mem [2**DRAM_ADDR_W];
    logic [DATA_W-1:0]      rd_word;
    logic [DATA_W-1:0]      result;
    logic [DRAM_ADDR_W-1:0] req_idx;
    logic                   accept;
    logic                   is_store, is_storeb;

    assign req_idx   = mmu_addr[DRAM_ADDR_W+1:2];
    assign accept    = mmu_valid && ready_q && (state_q == StIdle);
    assign is_store  = (mmu_opcode == I_STORE) || (mmu_opcode == I_STORER);
    assign is_storeb = (mmu_opcode == I_STOREB);

    // Stores commit at the accept edge; gating on nrst keeps a reset cycle from writing.
    always_ff @(posedge clk) begin
        if (nrst && accept) begin
            if (is_store) begin
                mem[req_idx] <= mmu_data;
            end else if (is_storeb) begin
                mem[req_idx][{mmu_addr[1:0], 3'b000} +: 8] <= mmu_data[7:0];
            end
        end
    end

    always_comb begin
        rd_word = mem[idx_q];
        result  = byte_q ? DATA_W'(rd_word[{lane_q, 3'b000} +: 8]) : rd_word;
    end

    always_comb begin
        state_d     = state_q;
        rsv_d       = rsv_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        byte_d      = byte_q;
        cdb_d       = cdb_q;
        cdb_valid_d = cdb_valid_q;
        ready_d     = ready_q;
        rx_ready_d  = rx_ready_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (accept) begin
                    rsv_d  = mmu_rsv_id;
                    idx_d  = req_idx;
                    lane_d = mmu_addr[1:0];
                    byte_d = (mmu_opcode == I_LOADB);
                    if (mmu_opcode == I_LOAD || mmu_opcode == I_LOADR ||
                        mmu_opcode == I_LOADB) begin
                        state_d = StRead;
                        ready_d = 1'b0;
                    end else if (mmu_opcode == I_INPUT) begin
                        state_d    = StInWait;
                        ready_d    = 1'b0;
                        rx_ready_d = 1'b1;
                    end else if (mmu_opcode == I_OUTPUT) begin
                        state_d    = StOutWait;
                        ready_d    = 1'b0;
                        tx_valid_d = 1'b1;
                        tx_data_d  = mmu_data[7:0];
                    end
                end
            end
            StRead: begin
                cdb_d       = {rsv_q, result};
                cdb_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (mmu_cdb_ready) begin
                    cdb_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = StIdle;
                end
            end
            StInWait: begin
                if (rx_valid && rx_ready_q) begin
                    cdb_d       = {rsv_q, DATA_W'(rx_data)};
                    cdb_valid_d = 1'b1;
                    rx_ready_d  = 1'b0;
                    state_d     = StResp;
                end
            end
            StOutWait: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    ready_d    = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= StIdle;
            rsv_q       <= '0;
            idx_q       <= '0;
            lane_q      <= '0;
            byte_q      <= 1'b0;
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rsv_q       <= rsv_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            byte_q      <= byte_d;
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
            ready_q     <= ready_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign mmu_ready     = ready_q;
    assign mmu_cdb       = cdb_q;
    assign mmu_cdb_valid = cdb_valid_q;
    assign rx_ready      = rx_ready_q;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;

endmodule
